// File: rtl/float_add_pipe_if.sv
// Operand/result handshake bundle for float_add_pipe: valid/ready on both sides.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface float_add_pipe_if #(
  parameter int EXP_WIDTH   = 5,
  parameter int MAN_WIDTH   = 10,
  parameter int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
);
  logic                   in_valid;
  logic                   in_ready;
  logic [FLOAT_WIDTH-1:0] float_a;
  logic [FLOAT_WIDTH-1:0] float_b;
  logic                   sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [FLOAT_WIDTH-1:0] res;
  logic [2:0]             flags;

  modport master (
    output in_valid, float_a, float_b, sub, out_ready,
    input  in_ready, out_valid, res, flags
  );

  modport slave (
    input  in_valid, float_a, float_b, sub, out_ready,
    output in_ready, out_valid, res, flags
  );
endinterface

// File: rtl/float_add_pipe.sv
// Pipelined float add/sub (S1 unpack/swap/align, S2 add, S3 normalise/round/pack); latency 3.
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module float_add_pipe #(
  parameter int EXP_WIDTH   = 5,
  parameter int MAN_WIDTH   = 10,
  parameter int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  float_add_pipe_if.slave bus
);
  localparam int E   = EXP_WIDTH;
  localparam int M   = MAN_WIDTH;
  localparam int AW  = M + 4;
  localparam int SW  = M + 5;
  localparam int LZW = $clog2(SW);
  localparam int XW  = E + 2;
  localparam logic [E-1:0] EXP_ONES = '1;
  localparam logic [E-1:0] SH_MAX   = E'(M + 3);
  localparam logic [FLOAT_WIDTH-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

  logic en;
  assign en = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic             a_s, b_s, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap, x_s;
  logic [E-1:0]     a_e, b_e, x_e, y_e, d, sh;
  logic [M-1:0]     a_m, b_m;
  logic [E+M-1:0]   a_mag, b_mag;
  logic [M:0]       a_sig, b_sig, x_sig, y_sig;
  logic [AW-1:0]    y_ext, y_al;
  logic             sp_c;
  logic [FLOAT_WIDTH-1:0] spr_c;
  logic [2:0]       spf_c;

  assign a_s    = bus.float_a[FLOAT_WIDTH-1];
  assign a_e    = bus.float_a[M +: E];
  assign a_m    = bus.float_a[M-1:0];
  assign b_s    = bus.float_b[FLOAT_WIDTH-1] ^ bus.sub;
  assign b_e    = bus.float_b[M +: E];
  assign b_m    = bus.float_b[M-1:0];
  // Subnormals carry exponent 0 and are treated as zero everywhere below.
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
  assign a_mag  = a_zero ? '0 : {a_e, a_m};
  assign b_mag  = b_zero ? '0 : {b_e, b_m};
  assign a_sig  = a_zero ? '0 : {1'b1, a_m};
  assign b_sig  = b_zero ? '0 : {1'b1, b_m};
  assign swap   = (b_mag > a_mag);
  assign x_s    = swap ? b_s   : a_s;
  assign x_e    = swap ? b_e   : a_e;
  assign y_e    = swap ? a_e   : b_e;
  assign x_sig  = swap ? b_sig : a_sig;
  assign y_sig  = swap ? a_sig : b_sig;
  assign d      = x_e - y_e;
  assign sh     = (d > SH_MAX) ? SH_MAX : d;
  assign y_ext  = {y_sig, 3'b000};
  assign y_al   = (y_ext >> sh) | AW'(|(y_ext & ~({AW{1'b1}} << sh)));

  always_comb begin
    sp_c  = 1'b1;
    spr_c = '0;
    spf_c = 3'b000;
    if (a_nan || b_nan) begin
      spr_c = QNAN;
    end else if (a_inf && b_inf && (a_s != b_s)) begin
      spr_c = QNAN;
      spf_c = 3'b100;
    end else if (a_inf) begin
      spr_c = {a_s, EXP_ONES, {M{1'b0}}};
    end else if (b_inf) begin
      spr_c = {b_s, EXP_ONES, {M{1'b0}}};
    end else if (a_zero && b_zero) begin
      spr_c = {a_s & b_s, {(E+M){1'b0}}};
    end else begin
      sp_c = 1'b0;
    end
  end

  logic                   v1, sp1, sign1, sub1;
  logic [FLOAT_WIDTH-1:0] spr1;
  logic [2:0]             spf1;
  logic [E-1:0]           e1;
  logic [AW-1:0]          xa1, ya1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sp1 <= 1'b0; sign1 <= 1'b0; sub1 <= 1'b0;
      spr1 <= '0; spf1 <= '0; e1 <= '0; xa1 <= '0; ya1 <= '0;
    end else if (en) begin
      v1    <= bus.in_valid;
      sp1   <= sp_c;
      spr1  <= spr_c;
      spf1  <= spf_c;
      sign1 <= x_s;
      sub1  <= a_s ^ b_s;
      e1    <= x_e;
      xa1   <= {x_sig, 3'b000};
      ya1   <= y_al;
    end
  end

  // ---------------- S2: magnitude add / subtract ----------------
  logic                   v2, sp2, sign2;
  logic [FLOAT_WIDTH-1:0] spr2;
  logic [2:0]             spf2;
  logic [E-1:0]           e2;
  logic [SW-1:0]          sum2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; sp2 <= 1'b0; sign2 <= 1'b0;
      spr2 <= '0; spf2 <= '0; e2 <= '0; sum2 <= '0;
    end else if (en) begin
      v2    <= v1;
      sp2   <= sp1;
      spr2  <= spr1;
      spf2  <= spf1;
      sign2 <= sign1;
      e2    <= e1;
      sum2  <= sub1 ? ({1'b0, xa1} - {1'b0, ya1}) : ({1'b0, xa1} + {1'b0, ya1});
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]         lz;
  logic [M+2:0]           n;
  logic [XW-1:0]          e_nrm, e_rnd;
  logic [M:0]             mr;
  logic                   rup, inx;
  logic [FLOAT_WIDTH-1:0] nres;
  logic [2:0]             nflg;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SW - 1; i++) begin
      if (sum2[i]) lz = LZW'(SW - 2 - i);
    end
    // n holds mantissa | guard | round | sticky with the hidden bit already dropped.
    if (sum2[SW-1]) begin
      n     = {sum2[M+3:2], |sum2[1:0]};
      e_nrm = {2'b00, e2} + XW'(1);
    end else begin
      n     = (M+3)'(sum2[M+3:0] << lz);
      e_nrm = {2'b00, e2} - XW'(lz);
    end
    rup   = n[2] & ((|n[1:0]) | n[3]);
    inx   = |n[2:0];
    mr    = {1'b0, n[M+2:3]} + (M+1)'(rup);
    e_rnd = e_nrm + XW'(mr[M]);
    nres  = '0;
    nflg  = 3'b000;
    if (sp2) begin
      nres = spr2;
      nflg = spf2;
    end else if (sum2 == '0) begin
      nres = '0;
    end else if (e_nrm[XW-1] || (e_nrm == '0)) begin
      nres = {sign2, {(E+M){1'b0}}};
      nflg = 3'b001;
    end else if (e_rnd >= {2'b00, EXP_ONES}) begin
      nres = {sign2, EXP_ONES, {M{1'b0}}};
      nflg = 3'b011;
    end else begin
      nres = {sign2, e_rnd[E-1:0], mr[M-1:0]};
      nflg = {2'b00, inx};
    end
  end

  logic                   ov_q;
  logic [FLOAT_WIDTH-1:0] res_q;
  logic [2:0]             flg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
    end else if (en) begin
      ov_q <= v2;
      if (v2) begin
        res_q <= nres;
        flg_q <= nflg;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.res       = res_q;
  assign bus.flags     = flg_q;
endmodule

// File: tb/tb_float_add_pipe.sv
// Bench for float_add_pipe: directed vector table, stall and reset sequences, random stream
// scored against a real-arithmetic reference model of binary16 add with flush-to-zero.
module tb_float_add_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_add_pipe_if bus ();
  float_add_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flg;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   chk_lat = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = real'(1024 + int'(h[9:0])) / 1024.0;
    for (int i = 0; i < e - 15; i++) v = v * 2.0;
    for (int i = 0; i < 15 - e; i++) v = v / 2.0;
    return v;
  endfunction

  // Returns {flags, res}: exact real sum, then round-to-nearest-even onto the binary16 grid.
  function automatic logic [18:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic sa, sb, sr, a_nan, b_nan, a_inf, b_inf;
    real  sum, mag, scaled, frac;
    int   e, be, ip;
    sa    = a[15];
    sb    = b[15] ^ s;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    if (a_nan || b_nan) return {3'b000, 16'h7E00};
    if (a_inf && b_inf && (sa != sb)) return {3'b100, 16'h7E00};
    if (a_inf) return {3'b000, sa, 15'h7C00};
    if (b_inf) return {3'b000, sb, 15'h7C00};
    if (a[14:10] == 5'h0 && b[14:10] == 5'h0) return {3'b000, sa & sb, 15'h0000};
    sum = (sa ? -h2r(a) : h2r(a)) + (sb ? -h2r(b) : h2r(b));
    if (sum == 0.0) return 19'h0;
    sr  = (sum < 0.0);
    mag = sr ? -sum : sum;
    e   = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0)  begin mag = mag * 2.0; e--; end
    be = e + 15;
    if (be <= 0) return {3'b001, sr, 15'h0000};
    scaled = mag * 1024.0;
    ip     = int'($floor(scaled));
    frac   = scaled - real'(ip);
    if (frac > 0.5 || (frac == 0.5 && (ip % 2) == 1)) ip++;
    if (ip == 2048) begin ip = 1024; be++; end
    if (be >= 31) return {3'b011, sr, 15'h7C00};
    return {2'b00, frac != 0.0, sr, 5'(be), 10'(ip)};
  endfunction

  // One clock: drive at the falling edge, then score the handshakes the next rising edge will make.
  task automatic cycle(input bit iv, input logic [15:0] a, input logic [15:0] b, input bit s,
                       input bit ordy, input logic [15:0] er, input logic [2:0] ef, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.float_a   = a;
    bus.float_b   = b;
    bus.sub       = s;
    bus.out_ready = ordy;
    #1;
    cyc++;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("res", 32'(bus.res), 32'(e.res));
        check("flags", 32'(bus.flags), 32'(e.flg));
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
      end
    end
    if (acc) sb_q.push_back('{er, ef, cyc});
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    cycle(1'b0, 16'h0, 16'h0, 1'b0, ordy, 16'h0, 3'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1'b1);
    check("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic gen(output logic [15:0] a, output logic [15:0] b, output logic s);
    a = 16'($urandom);
    b = 16'($urandom);
    s = 1'($urandom);
    if ($urandom_range(0, 1) == 1) b[14:10] = a[14:10] ^ 5'($urandom_range(0, 1));
  endtask

  vec_t        tv[20];
  logic [15:0] sa[8], sbv[8];
  logic        ss[8];

  initial begin
    bit          acc;
    logic [18:0] m;
    logic [15:0] ra, rb, held_r;
    logic [2:0]  held_f;
    logic        rs;
    int          idx, base, stale, n_in;

    tv[0]  = '{16'h34CD, 16'h3266, 1'b0, 16'h3800, 3'b000};
    tv[1]  = '{16'h34CD, 16'h34CD, 1'b0, 16'h38CD, 3'b000};
    tv[2]  = '{16'h6108, 16'hF103, 1'b0, 16'hF0B2, 3'b001};
    tv[3]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011};
    tv[4]  = '{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b100};
    tv[5]  = '{16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b000};
    tv[6]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000};
    tv[7]  = '{16'hFC00, 16'hFC00, 1'b0, 16'hFC00, 3'b000};
    tv[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000};
    tv[9]  = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000};
    tv[10] = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000};
    tv[11] = '{16'h0001, 16'h0000, 1'b0, 16'h0000, 3'b000};
    tv[12] = '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b000};
    tv[13] = '{16'hFC00, 16'hFC00, 1'b1, 16'h7E00, 3'b100};
    tv[14] = '{16'h0400, 16'h0401, 1'b1, 16'h8000, 3'b001};
    tv[15] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001};
    tv[16] = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001};
    tv[17] = '{16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b001};
    tv[18] = '{16'h7BFF, 16'h5000, 1'b0, 16'h7C00, 3'b011};
    tv[19] = '{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 3'b011};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.float_a = '0; bus.float_b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Directed vectors, back to back with the consumer always ready.
    chk_lat = 1'b1;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, tv[i].a, tv[i].b, tv[i].s, 1'b1, tv[i].res, tv[i].flg, acc);
    drain();

    // Eight-pair stream with a four-cycle consumer stall in the middle.
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) gen(sa[i], sbv[i], ss[i]);
    idx = 0; base = n_out; held_r = '0; held_f = '0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 8) begin
        m = ref_add(sa[idx], sbv[idx], ss[idx]);
        cycle(1'b1, sa[idx], sbv[idx], ss[idx], !(c >= 4 && c < 8), m[15:0], m[18:16], acc);
        if (acc) idx++;
      end else begin
        idle(1'b1);
      end
      if (c == 4) begin
        held_r = bus.res;
        held_f = bus.flags;
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      if (c >= 4 && c < 8) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (c > 4 && c < 8) begin
        check("stall_res_stable", 32'(bus.res), 32'(held_r));
        check("stall_flags_stable", 32'(bus.flags), 32'(held_f));
        check("stall_valid_stable", 32'(bus.out_valid), 32'd1);
      end
      if (idx == 8 && sb_q.size() == 0) break;
    end
    check("stream_accepted", 32'(idx), 32'd8);
    check("stream_results", 32'(n_out - base), 32'd8);

    // Reset with three operations in flight.
    chk_lat = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gen(ra, rb, rs);
      m = ref_add(ra, rb, rs);
      cycle(1'b1, ra, rb, rs, 1'b1, m[15:0], m[18:16], acc);
    end
    idle(1'b0);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_res", 32'(bus.res), 32'd0);
    check("mid_rst_flags", 32'(bus.flags), 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      if (bus.out_valid) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    cycle(1'b1, 16'h34CD, 16'h3266, 1'b0, 1'b1, 16'h3800, 3'b000, acc);
    drain();

    // Random stream with random input gaps and consumer stalls.
    chk_lat = 1'b0;
    n_in = 0;
    gen(ra, rb, rs);
    for (int c = 0; c < 3000 && n_in < 400; c++) begin
      m = ref_add(ra, rb, rs);
      cycle($urandom_range(0, 3) != 0, ra, rb, rs, $urandom_range(0, 3) != 0, m[15:0], m[18:16], acc);
      if (acc) begin
        n_in++;
        gen(ra, rb, rs);
      end
    end
    check("rand_accepted", 32'(n_in), 32'd400);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, %0d compared so far", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
